mc_delay_line: RTL
==================

Name: mc_delay_line

Overview:
- Multichannel, runtime-programmable audio delay line; successor to the fixed-delay single-channel circular buffer.
- Channel-interleaved sample stream in, same stream out, each channel delayed by `delay_cfg` frames.
- Sits between the input deserialiser and the effects mixer.
- Storage is an inferred simple dual-port RAM, partitioned per channel.

Parameters:
- DATA_W, 24, sample width (signed two's complement)
- NUM_CH, 2, channel count, 1..16
- MAX_DELAY, 65536, frames of storage per channel; must be a power of two
- CH_W, $clog2(NUM_CH) (minimum 1), channel index width (derived, localparam)
- DLY_W, $clog2(MAX_DELAY), delay/pointer width (derived, localparam)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample strobe
- in_ch  in  CH_W  channel index of input sample
- in_data  in  DATA_W  input sample
- delay_cfg  in  DLY_W  requested delay in frames
- delay_upd  in  1  pulse: latch `delay_cfg` at next frame boundary
- out_valid  out  1  output sample strobe
- out_ch  out  CH_W  channel index of output sample
- out_data  out  DATA_W  delayed sample
- out_primed  out  1  high once the active delay is fully backed by written data
- err_seq  out  1  sticky: channel order or spacing violation; cleared only by reset

Behaviour:
- Reset: async assert, sync release. All outputs 0; `wr_ptr`=0, `exp_ch`=0, `fill_cnt`=0, active delay=1, pending update cleared. RAM contents are not reset.
- Addressing: RAM address = {ch, ptr}, depth NUM_CH*MAX_DELAY.
- Input framing:
  - Samples must arrive in order 0..NUM_CH-1.
  - `in_ch` != `exp_ch` → set `err_seq`, drop the sample. If `in_ch`==0, resync: accept it as channel 0 of a new frame, `wr_ptr` not advanced.
- Spacing: consecutive `in_valid` pulses must be ≥3 cycles apart. A closer pulse is dropped and sets `err_seq`.
- Pipeline, fixed latency 2 cycles (`in_valid` at T → `out_valid` at T+2):
  - S0: register sample; issue read at {ch, wr_ptr − d_act} mod MAX_DELAY.
  - S1: RAM read data.
  - S2: drive `out_*`; write {ch, wr_ptr} with the S2 write value.
- Frame boundary: accepted sample with ch==NUM_CH-1:
  - `wr_ptr` += 1, wrapping MAX_DELAY-1 → 0.
  - `fill_cnt` += 1, saturating at MAX_DELAY-1.
  - If an update is pending, `d_act` ← clamp(`delay_cfg` latched at the `delay_upd` pulse).
- Delay clamp: 0 → 1; range 1..MAX_DELAY-1. `delay_upd` while an update is pending overwrites the pending value (last wins).
- Warm-up: while `d_act` > `fill_cnt`, `out_data`=0 and `out_primed`=0; otherwise `out_data`=RAM value and `out_primed`=1. Increasing the delay mid-run can re-enter warm-up.
- `out_valid` is a 1-cycle pulse; `out_ch` mirrors the accepted channel; `out_data` holds between pulses.
- Reset mid-stream: the pipeline is flushed, no `out_valid` is emitted for in-flight samples, and warm-up restarts.

Optional Feature:
MC_DELAY_FEEDBACK_EN
- With the macro:
  - Adds port `fb_gain` in, 16 bits, unsigned Q1.15.
  - Write value = sat_DATA_W(in + ((delayed × fb_gain) >>> 15)), using a (DATA_W+17)-bit intermediate, saturating to signed max/min. This produces a feedback echo.
  - `delayed` is 0 during warm-up.
- Without the macro: no `fb_gain` port; write value = in.

Decomposition:
- Package `mc_delay_pkg`:
  - saturate function
  - Q1.15 constants: FB_ONE=16'h8000, FB_HALF=16'h4000
  - error-code localparams
- Sub-module `sdp_ram` (parameters WIDTH, DEPTH; 1-cycle registered read, independent write port) isolates the RAM for later DDR substitution.
- Sequencing, pointers and the feedback datapath stay in the top level.

Test Plan:
- NUM_CH=2, delay_cfg=4 with update at reset release; feed ramp ch0=k, ch1=1000+k, spacing 4 cycles → zeros with `out_primed`=0 for frames 0..3; from frame 4, ch0 out=k−4 and ch1 out=1000+k−4; latency exactly 2 cycles.
- Wrap: MAX_DELAY=8, delay=7, run 20 frames → output frame n = input frame n−7, continuous across `wr_ptr` 7→0.
- Delay change 4→2 mid-stream, pulse mid-frame → new delay applies from the next frame; the first output of that frame equals input frame n−2.
- Order error: send ch1 where ch0 expected → sample dropped, `err_seq`=1 and stays high. A following ch0 is accepted and output continues.
- Spacing violation: two `in_valid` pulses 1 cycle apart → second dropped, `err_seq`=1; `delay_cfg`=0 → behaves as delay 1.
- With MC_DELAY_FEEDBACK_EN: fb_gain=16'h4000, delay=1, NUM_CH=1, impulse 1000 then zeros → outputs 0, 1000, 500, 250, 125. Impulse 24'h7FFFFF held constant → write value saturates at 24'h7FFFFF.

Source files
------------

// File: rtl/mc_delay_pkg.sv
// mc_delay_pkg: shared constants and helpers for the multichannel delay line.
package mc_delay_pkg;

  // Q1.15 feedback gain constants
  localparam logic [15:0] FB_ONE  = 16'h8000;
  localparam logic [15:0] FB_HALF = 16'h4000;

  // Sequencing error codes
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ORDER   = 2'd1;
  localparam logic [1:0] ERR_SPACING = 2'd2;

  // Clamp a signed value to the range of a w-bit signed number (w <= 64).
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                     input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/mc_delay_line_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port.
// Kept separate so an external memory can be substituted later.
module sdp_ram #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read, one cycle latency; contents are never reset
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mc_delay_line.sv
// mc_delay_line: channel-interleaved, runtime-programmable audio delay line.
// Define MC_DELAY_FEEDBACK_EN to add the fb_gain port and the saturating feedback echo path.
module mc_delay_line
  import mc_delay_pkg::*;
#(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned MAX_DELAY = 65536,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned DLY_W    = $clog2(MAX_DELAY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DLY_W-1:0]  delay_cfg,
  input  logic              delay_upd,
`ifdef MC_DELAY_FEEDBACK_EN
  input  logic [15:0]       fb_gain,
`endif
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              out_primed,
  output logic              err_seq
);

  localparam int unsigned     RAM_DEPTH = NUM_CH * MAX_DELAY;
  localparam int unsigned     RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);

  // Sequencing / pointer state
  logic [1:0]        gap_q, gap_d;
  logic [CH_W-1:0]   exp_ch_q, exp_ch_d;
  logic [DLY_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DLY_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [DLY_W-1:0]  d_act_q, d_act_d;
  logic              pend_q, pend_d;
  logic [DLY_W-1:0]  pend_val_q, pend_val_d;
  logic              err_q;

  // S1 stage (RAM read in flight)
  logic              s1_valid_q;
  logic [CH_W-1:0]   s1_ch_q;
  logic [DLY_W-1:0]  s1_ptr_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_primed_q;

  // Output registers
  logic              out_valid_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_primed_q;

  logic [1:0]              err_code;
  logic                    accept;
  logic                    frame_end;
  logic                    primed_s0;
  logic [DLY_W-1:0]        rd_ptr;
  logic [CH_W+DLY_W-1:0]   rd_addr_full;
  logic [CH_W+DLY_W-1:0]   wr_addr_full;
  logic [RAM_AW-1:0]       ram_raddr;
  logic [RAM_AW-1:0]       ram_waddr;
  logic [DATA_W-1:0]       ram_rdata;
  logic [DATA_W-1:0]       delayed;
  logic [DATA_W-1:0]       wr_val;

  // Classify the incoming sample: spacing violations win over order checks.
  // A channel-0 sample arriving out of order is still taken as a frame restart.
  always_comb begin
    err_code = ERR_NONE;
    accept   = 1'b0;
    if (in_valid) begin
      if (gap_q < 2'd2) begin
        err_code = ERR_SPACING;
      end else if (in_ch != exp_ch_q) begin
        err_code = ERR_ORDER;
        accept   = (in_ch == '0);
      end else begin
        accept = 1'b1;
      end
    end
  end

  assign frame_end = accept && (in_ch == LAST_CH);

  // Next-state for spacing counter, channel expectation, pointers and delay update
  always_comb begin
    gap_d      = gap_q;
    exp_ch_d   = exp_ch_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    d_act_d    = d_act_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;

    // gap_q counts cycles since the last in_valid, saturating at 3
    if (in_valid) begin
      gap_d = '0;
    end else if (gap_q != 2'd3) begin
      gap_d = gap_q + 2'd1;
    end

    if (accept) begin
      exp_ch_d = frame_end ? '0 : in_ch + CH_W'(1);
    end

    if (frame_end) begin
      wr_ptr_d = wr_ptr_q + DLY_W'(1);
      if (fill_cnt_q != '1) begin
        fill_cnt_d = fill_cnt_q + DLY_W'(1);
      end
      if (pend_q) begin
        d_act_d = (pend_val_q == '0) ? DLY_W'(1) : pend_val_q;
        pend_d  = 1'b0;
      end
    end

    // A pulse coinciding with a boundary stays pending for the next one
    if (delay_upd) begin
      pend_d     = 1'b1;
      pend_val_d = delay_cfg;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q      <= 2'd3;
      exp_ch_q   <= '0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      d_act_q    <= DLY_W'(1);
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      err_q      <= 1'b0;
    end else begin
      gap_q      <= gap_d;
      exp_ch_q   <= exp_ch_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      d_act_q    <= d_act_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      err_q      <= err_q | (err_code != ERR_NONE);
    end
  end

  // S0: read address wraps within the channel's partition
  assign rd_ptr       = wr_ptr_q - d_act_q;
  assign rd_addr_full = {in_ch, rd_ptr};
  assign ram_raddr    = rd_addr_full[RAM_AW-1:0];
  assign primed_s0    = (d_act_q <= fill_cnt_q);

  // S0 -> S1 pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_ptr_q    <= '0;
      s1_data_q   <= '0;
      s1_primed_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_ch_q     <= in_ch;
        s1_ptr_q    <= wr_ptr_q;
        s1_data_q   <= in_data;
        s1_primed_q <= primed_s0;
      end
    end
  end

  // Unbacked locations read as silence during warm-up
  assign delayed = s1_primed_q ? ram_rdata : '0;

`ifdef MC_DELAY_FEEDBACK_EN
  localparam int unsigned FB_W = DATA_W + 17;

  logic signed [FB_W-1:0] fb_delayed;
  logic signed [FB_W-1:0] fb_gain_ext;
  logic signed [FB_W-1:0] fb_in;
  logic signed [FB_W-1:0] fb_prod;
  logic signed [FB_W-1:0] fb_sum;

  assign fb_delayed  = FB_W'($signed(delayed));
  assign fb_gain_ext = FB_W'($signed({1'b0, fb_gain}));
  assign fb_in       = FB_W'($signed(s1_data_q));
  assign fb_prod     = fb_delayed * fb_gain_ext;
  assign fb_sum      = (fb_prod >>> 15) + fb_in;
  assign wr_val      = DATA_W'(sat_signed(64'(fb_sum), DATA_W));
`else
  assign wr_val = s1_data_q;
`endif

  assign wr_addr_full = {s1_ch_q, s1_ptr_q};
  assign ram_waddr    = wr_addr_full[RAM_AW-1:0];

  sdp_ram #(
    .WIDTH (DATA_W),
    .DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (s1_valid_q),
    .waddr (ram_waddr),
    .wdata (wr_val),
    .re    (accept),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // S2: output registers; data and primed hold between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_data_q   <= '0;
      out_primed_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_ch_q     <= s1_ch_q;
        out_data_q   <= delayed;
        out_primed_q <= s1_primed_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_data   = out_data_q;
  assign out_primed = out_primed_q;
  assign err_seq    = err_q;

endmodule
